axis_zmod_trigger: RTL and testbench
====================================

Name: axis_zmod_trigger

Overview:
- Sits directly downstream of the Zmod ADC DDR capture stage and consumes its always-valid 32-bit stream: channel A in [15:0], channel B in [31:16], both signed and sign-extended.
- Once armed, it waits for a level-crossing trigger on a selected channel, or for a forced trigger.
- It then emits a packet of CNTR_WIDTH-bounded length on a back-pressurable AXI4-Stream master, with tlast on the final beat.
- It reports dropped samples, state, and optionally a trigger timestamp.

Parameters:
- AXIS_TDATA_WIDTH, 32, sample word width; two signed 16-bit channels.
- CNTR_WIDTH, 32, width of the packet length counter and the drop counter.

Ports:
- aclk  input  1  clock.
- aresetn  input  1  reset; synchronous, active-low.
- s_axis_tdata  input  AXIS_TDATA_WIDTH  sample pair from the ADC stage.
- s_axis_tvalid  input  1  sample valid; always 1 from upstream, but honoured.
- m_axis_tdata  output  AXIS_TDATA_WIDTH  captured sample pair.
- m_axis_tvalid  output  1  output beat valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tlast  output  1  final beat of packet.
- cfg_level  input  16  signed trigger level.
- cfg_chan  input  1  0 = channel A, 1 = channel B.
- cfg_edge  input  1  0 = rising, 1 = falling.
- cfg_length  input  CNTR_WIDTH  samples per packet.
- arm  input  1  single-cycle arm request.
- trg_force  input  1  force trigger.
- sts_state  output  2  0 = IDLE, 1 = ARMED, 2 = CAPTURE.
- sts_drops  output  CNTR_WIDTH  dropped-sample count, saturating.

Behaviour:
- **Reset** (aresetn low at posedge):
  - state IDLE.
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0.
  - sts_drops = 0, prev-sample register = 0, counters = 0.
  - Reset mid-capture abandons the packet immediately.
- **Input qualification:** a sample is "present" when s_axis_tvalid = 1. All per-sample logic advances only on present samples.
- **Previous-sample register:**
  - Holds the selected channel's last present sample.
  - Updates on every present sample in every state.
- **Trigger condition** (signed 16-bit compare, cur = selected channel of current sample):
  - Rising: prev < cfg_level AND cur >= cfg_level.
  - Falling: prev > cfg_level AND cur <= cfg_level.
- **IDLE:**
  - arm = 1 → ARMED.
  - cfg_length is latched; 0 is treated as 1.
  - trg_force is ignored in IDLE.
- **ARMED:**
  - On a present sample, if the trigger condition holds or trg_force = 1 → CAPTURE.
  - The triggering sample is packet sample 0.
  - arm is ignored while ARMED.
- **CAPTURE:**
  - Sample counter counts presented samples 0..L-1, where L is the latched length.
  - arm is ignored while CAPTURE.
- **Output register** (single beat):
  - A sample present in cycle t loads the register → m_axis_tvalid = 1 at t+1, giving 1-cycle latency.
  - Register is empty when tvalid = 0, or when tvalid & tready in the same cycle.
  - If full and not being drained: the sample is dropped, sts_drops increments (saturating at all-ones), and the sample counter still advances.
- **tlast:**
  - Set on the beat carrying sample L-1.
  - If sample L-1 is dropped, tlast is set on the held beat instead.
- **Packet completion:** the beat with tlast handshakes → IDLE. The same cycle may accept arm and go to ARMED.
- **AXI-Stream rule:** tdata/tlast remain stable while tvalid = 1 and tready = 0.
- **sts_drops:** cumulative across packets; cleared only by reset.

Optional Feature:
- **Macro:** AXIS_ZMOD_TRIGGER_TIMESTAMP_EN.
- **Defined:**
  - Adds a free-running 64-bit sample counter, incremented per present sample and reset to 0.
  - Adds output sts_timestamp [63:0], loaded with the counter value of the triggering sample on entry to CAPTURE.
  - sts_timestamp holds until the next trigger; reset value 0.
- **Undefined:** no counter and no port.

Test Plan:
- **Rising trigger:** cfg_chan = 0, cfg_edge = 0, cfg_level = 100, cfg_length = 4, arm, then A ramps 96, 98, 100, 102, 104, 106 with tready = 1 → 4 beats carrying A = 100, 102, 104, 106; tlast on the 106 beat; sts_state returns to 0; sts_drops = 0.
- **Falling trigger, channel B:** cfg_chan = 1, cfg_edge = 1, cfg_level = -50, B sequence -40, -50 → capture starts at -50. Repeat with level -60 and the same data → no trigger; stays ARMED.
- **Force:** trg_force pulsed 3 cycles after arm, data flat 0 → packet starts with the sample present in the force cycle. trg_force pulsed while IDLE → no effect.
- **Backpressure:** cfg_length = 8, tready low for cycles 2–4 of the capture → held beat stable; sts_drops = 3; 5 beats delivered; tlast on the final delivered beat.
- **Length 0:** cfg_length = 0 → exactly 1 beat, with tlast = 1.
- **Reset mid-capture:** aresetn low during beat 2 of 8 → next cycle tvalid = 0, sts_state = 0, sts_drops = 0. With the timestamp macro defined, a trigger at sample 37 after reset gives sts_timestamp = 37.

Source files
------------

// File: rtl/axis_zmod_trigger.sv
// Level/edge trigger and packet capture for the Zmod ADC sample stream.
// Optional trigger timestamp: define AXIS_ZMOD_TRIGGER_TIMESTAMP_EN.
module axis_zmod_trigger #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    input  logic [15:0]                 cfg_level,
    input  logic                        cfg_chan,
    input  logic                        cfg_edge,
    input  logic [CNTR_WIDTH-1:0]       cfg_length,
    input  logic                        arm,
    input  logic                        trg_force,
    output logic [1:0]                  sts_state,
    output logic [CNTR_WIDTH-1:0]       sts_drops
`ifdef AXIS_ZMOD_TRIGGER_TIMESTAMP_EN
    ,
    output logic [63:0]                 sts_timestamp
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic [CNTR_WIDTH-1:0] CNT_ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

    state_t                      state_q, state_d;
    logic signed [15:0]          prev_q, prev_d;
    logic [CNTR_WIDTH-1:0]       len_q, len_d;
    logic [CNTR_WIDTH-1:0]       cnt_q, cnt_d;
    logic [CNTR_WIDTH-1:0]       drops_q, drops_d;
    logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                        tvalid_q, tvalid_d;
    logic                        tlast_q, tlast_d;
`ifdef AXIS_ZMOD_TRIGGER_TIMESTAMP_EN
    logic [63:0]                 ts_cnt_q, ts_cnt_d;
    logic [63:0]                 ts_q, ts_d;
`endif

    logic signed [15:0]    cur;
    logic signed [15:0]    level;
    logic                  present;
    logic                  trig;
    logic                  drain;
    logic                  take;
    logic                  last;
    logic [CNTR_WIDTH-1:0] arm_len;

    assign present = s_axis_tvalid;
    assign cur     = cfg_chan ? s_axis_tdata[31:16] : s_axis_tdata[15:0];
    assign level   = cfg_level;
    assign trig    = cfg_edge ? ((prev_q > level) && (cur <= level))
                              : ((prev_q < level) && (cur >= level));
    assign drain   = tvalid_q & m_axis_tready;
    assign arm_len = (cfg_length == '0) ? CNT_ONE : cfg_length;

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        drops_d  = drops_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        take     = 1'b0;
        last     = 1'b0;
`ifdef AXIS_ZMOD_TRIGGER_TIMESTAMP_EN
        ts_cnt_d = ts_cnt_q;
        ts_d     = ts_q;
        if (present) begin
            ts_cnt_d = ts_cnt_q + 64'd1;
        end
`endif

        if (present) begin
            prev_d = cur;
        end
        if (drain) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d = ST_ARMED;
                    len_d   = arm_len;
                end
            end
            ST_ARMED: begin
                if (present && (trig || trg_force)) begin
                    state_d = ST_CAPTURE;
                    take    = 1'b1;
                    last    = (len_q == CNT_ONE);
                    cnt_d   = CNT_ONE;
`ifdef AXIS_ZMOD_TRIGGER_TIMESTAMP_EN
                    ts_d    = ts_cnt_q;
`endif
                end
            end
            ST_CAPTURE: begin
                // cnt_q == len_q means every sample is taken; only the tlast beat remains
                if (present && (cnt_q != len_q)) begin
                    take  = 1'b1;
                    last  = (cnt_q == (len_q - CNT_ONE));
                    cnt_d = cnt_q + CNT_ONE;
                end
                if (drain && tlast_q) begin
                    cnt_d   = '0;
                    state_d = arm ? ST_ARMED : ST_IDLE;
                    if (arm) begin
                        len_d = arm_len;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A full, undrained register keeps its beat; the final sample's tlast moves onto it
        if (take) begin
            if (!tvalid_q || m_axis_tready) begin
                tdata_d  = s_axis_tdata;
                tvalid_d = 1'b1;
                tlast_d  = last;
            end else begin
                if (drops_q != '1) begin
                    drops_d = drops_q + CNT_ONE;
                end
                if (last) begin
                    tlast_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            prev_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            drops_q  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
`ifdef AXIS_ZMOD_TRIGGER_TIMESTAMP_EN
            ts_cnt_q <= '0;
            ts_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            drops_q  <= drops_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
`ifdef AXIS_ZMOD_TRIGGER_TIMESTAMP_EN
            ts_cnt_q <= ts_cnt_d;
            ts_q     <= ts_d;
`endif
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign sts_state     = state_q;
    assign sts_drops     = drops_q;
`ifdef AXIS_ZMOD_TRIGGER_TIMESTAMP_EN
    assign sts_timestamp = ts_q;
`endif

endmodule

// File: tb/tb_axis_zmod_trigger.sv
// Directed bench for axis_zmod_trigger: trigger modes, backpressure, length edge cases, reset.
module tb_axis_zmod_trigger;

    logic        aclk;
    logic        aresetn;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [15:0] cfg_level;
    logic        cfg_chan;
    logic        cfg_edge;
    logic [31:0] cfg_length;
    logic        arm;
    logic        trg_force;
    logic [1:0]  sts_state;
    logic [31:0] sts_drops;
`ifdef AXIS_ZMOD_TRIGGER_TIMESTAMP_EN
    logic [63:0] sts_timestamp;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] beats[$];

    axis_zmod_trigger #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(32)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .cfg_level     (cfg_level),
        .cfg_chan      (cfg_chan),
        .cfg_edge      (cfg_edge),
        .cfg_length    (cfg_length),
        .arm           (arm),
        .trg_force     (trg_force),
        .sts_state     (sts_state),
        .sts_drops     (sts_drops)
`ifdef AXIS_ZMOD_TRIGGER_TIMESTAMP_EN
        ,
        .sts_timestamp (sts_timestamp)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // One clock per call: inputs change at the negedge, handshakes are logged just before the posedge
    task automatic step(input logic [15:0] a, input logic [15:0] b,
                        input logic arm_i, input logic force_i, input logic ready_i);
        s_axis_tdata  = {b, a};
        arm           = arm_i;
        trg_force     = force_i;
        m_axis_tready = ready_i;
        #3;
        if (aresetn && m_axis_tvalid && m_axis_tready)
            beats.push_back({m_axis_tlast, m_axis_tdata});
        @(negedge aclk);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        step(16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        step(16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        step(16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tvalid got %b expected 0", m_axis_tvalid); end
        n_checks++; if (m_axis_tlast !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tlast got %b expected 0", m_axis_tlast); end
        n_checks++; if (m_axis_tdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_tdata got %h expected 0", m_axis_tdata); end
        n_checks++; if (sts_state !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_state got %0d expected 0", sts_state); end
        n_checks++; if (sts_drops !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_drops got %0d expected 0", sts_drops); end
`ifdef AXIS_ZMOD_TRIGGER_TIMESTAMP_EN
        n_checks++; if (sts_timestamp !== 64'd0) begin n_fail++; $display("[TB] FAIL reset_ts got %0d expected 0", sts_timestamp); end
`endif
        aresetn = 1'b1;
    endtask

    task automatic test_rising();
        logic [32:0] exp[4];
        logic [32:0] got;
        exp = '{{1'b0, 16'd0, 16'd100}, {1'b0, 16'd0, 16'd102},
                {1'b0, 16'd0, 16'd104}, {1'b1, 16'd0, 16'd106}};
        cfg_chan = 1'b0; cfg_edge = 1'b0; cfg_level = 16'd100; cfg_length = 32'd4;
        beats.delete();
        step(16'd0, 16'd0, 1'b1, 1'b0, 1'b1);
        n_checks++; if (sts_state !== 2'd1) begin n_fail++; $display("[TB] FAIL rise_armed got %0d expected 1", sts_state); end
        step(16'd96, 16'd0, 1'b0, 1'b0, 1'b1);
        step(16'd98, 16'd0, 1'b0, 1'b0, 1'b1);
        step(16'd100, 16'd0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (sts_state !== 2'd2) begin n_fail++; $display("[TB] FAIL rise_capture got %0d expected 2", sts_state); end
        n_checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd100) begin n_fail++; $display("[TB] FAIL rise_latency got v=%b d=%h expected v=1 d=00000064", m_axis_tvalid, m_axis_tdata); end
        step(16'd102, 16'd0, 1'b0, 1'b0, 1'b1);
        step(16'd104, 16'd0, 1'b0, 1'b0, 1'b1);
        step(16'd106, 16'd0, 1'b0, 1'b0, 1'b1);
        step(16'd108, 16'd0, 1'b0, 1'b0, 1'b1);
        step(16'd110, 16'd0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (beats.size() != 4) begin n_fail++; $display("[TB] FAIL rise_count got %0d expected 4", beats.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < beats.size()) ? beats[i] : 33'h0;
            n_checks++; if (got !== exp[i]) begin n_fail++; $display("[TB] FAIL rise_beat%0d got %h expected %h", i, got, exp[i]); end
        end
        n_checks++; if (sts_state !== 2'd0) begin n_fail++; $display("[TB] FAIL rise_idle got %0d expected 0", sts_state); end
        n_checks++; if (sts_drops !== 32'd0) begin n_fail++; $display("[TB] FAIL rise_drops got %0d expected 0", sts_drops); end
    endtask

    task automatic test_falling_b();
        logic [32:0] exp[2];
        logic [32:0] got;
        exp = '{{1'b0, -16'sd50, 16'd0}, {1'b1, -16'sd60, 16'd0}};
        cfg_chan = 1'b1; cfg_edge = 1'b1; cfg_level = -16'sd50; cfg_length = 32'd2;
        beats.delete();
        step(16'd0, -16'sd40, 1'b1, 1'b0, 1'b1);
        step(16'd0, -16'sd50, 1'b0, 1'b0, 1'b1);
        n_checks++; if (sts_state !== 2'd2) begin n_fail++; $display("[TB] FAIL fall_capture got %0d expected 2", sts_state); end
        step(16'd0, -16'sd60, 1'b0, 1'b0, 1'b1);
        step(16'd0, -16'sd70, 1'b0, 1'b0, 1'b1);
        step(16'd0, -16'sd70, 1'b0, 1'b0, 1'b1);
        n_checks++; if (beats.size() != 2) begin n_fail++; $display("[TB] FAIL fall_count got %0d expected 2", beats.size()); end
        for (int i = 0; i < 2; i++) begin
            got = (i < beats.size()) ? beats[i] : 33'h0;
            n_checks++; if (got !== exp[i]) begin n_fail++; $display("[TB] FAIL fall_beat%0d got %h expected %h", i, got, exp[i]); end
        end
        cfg_level = -16'sd60;
        beats.delete();
        step(16'd0, -16'sd40, 1'b1, 1'b0, 1'b1);
        step(16'd0, -16'sd50, 1'b0, 1'b0, 1'b1);
        step(16'd0, -16'sd40, 1'b0, 1'b0, 1'b1);
        step(16'd0, -16'sd50, 1'b0, 1'b0, 1'b1);
        n_checks++; if (sts_state !== 2'd1) begin n_fail++; $display("[TB] FAIL fall_notrig_state got %0d expected 1", sts_state); end
        n_checks++; if (m_axis_tvalid !== 1'b0 || beats.size() != 0) begin n_fail++; $display("[TB] FAIL fall_notrig_out got v=%b n=%0d expected v=0 n=0", m_axis_tvalid, beats.size()); end
        do_reset();
    endtask

    task automatic test_force();
        logic [32:0] exp[2];
        logic [32:0] got;
        exp = '{{1'b0, 16'd4, 16'd0}, {1'b1, 16'd5, 16'd0}};
        cfg_chan = 1'b0; cfg_edge = 1'b0; cfg_level = 16'd100; cfg_length = 32'd2;
        beats.delete();
        step(16'd0, 16'd9, 1'b0, 1'b1, 1'b1);
        n_checks++; if (sts_state !== 2'd0 || m_axis_tvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL force_idle got s=%0d v=%b expected s=0 v=0", sts_state, m_axis_tvalid); end
        step(16'd0, 16'd1, 1'b1, 1'b0, 1'b1);
        step(16'd0, 16'd2, 1'b0, 1'b0, 1'b1);
        step(16'd0, 16'd3, 1'b0, 1'b0, 1'b1);
        n_checks++; if (sts_state !== 2'd1) begin n_fail++; $display("[TB] FAIL force_wait got %0d expected 1", sts_state); end
        step(16'd0, 16'd4, 1'b0, 1'b1, 1'b1);
        n_checks++; if (sts_state !== 2'd2) begin n_fail++; $display("[TB] FAIL force_capture got %0d expected 2", sts_state); end
        step(16'd0, 16'd5, 1'b0, 1'b0, 1'b1);
        step(16'd0, 16'd6, 1'b0, 1'b0, 1'b1);
        step(16'd0, 16'd7, 1'b0, 1'b0, 1'b1);
        n_checks++; if (beats.size() != 2) begin n_fail++; $display("[TB] FAIL force_count got %0d expected 2", beats.size()); end
        for (int i = 0; i < 2; i++) begin
            got = (i < beats.size()) ? beats[i] : 33'h0;
            n_checks++; if (got !== exp[i]) begin n_fail++; $display("[TB] FAIL force_beat%0d got %h expected %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] exp[5];
        logic [32:0] got;
        exp = '{{1'b0, 16'd0, 16'd100}, {1'b0, 16'd0, 16'd101}, {1'b0, 16'd0, 16'd105},
                {1'b0, 16'd0, 16'd106}, {1'b1, 16'd0, 16'd107}};
        cfg_chan = 1'b0; cfg_edge = 1'b0; cfg_level = 16'd100; cfg_length = 32'd8;
        beats.delete();
        step(16'd0, 16'd0, 1'b1, 1'b0, 1'b1);
        step(16'd100, 16'd0, 1'b0, 1'b0, 1'b1);
        step(16'd101, 16'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(16'(102 + k), 16'd0, 1'b0, 1'b0, 1'b0);
            n_checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd101 || m_axis_tlast !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_hold%0d got v=%b d=%h l=%b expected v=1 d=00000065 l=0", k, m_axis_tvalid, m_axis_tdata, m_axis_tlast); end
        end
        step(16'd105, 16'd0, 1'b0, 1'b0, 1'b1);
        step(16'd106, 16'd0, 1'b0, 1'b0, 1'b1);
        step(16'd107, 16'd0, 1'b0, 1'b0, 1'b1);
        step(16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        step(16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (sts_drops !== 32'd3) begin n_fail++; $display("[TB] FAIL bp_drops got %0d expected 3", sts_drops); end
        n_checks++; if (beats.size() != 5) begin n_fail++; $display("[TB] FAIL bp_count got %0d expected 5", beats.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < beats.size()) ? beats[i] : 33'h0;
            n_checks++; if (got !== exp[i]) begin n_fail++; $display("[TB] FAIL bp_beat%0d got %h expected %h", i, got, exp[i]); end
        end
        n_checks++; if (sts_state !== 2'd0) begin n_fail++; $display("[TB] FAIL bp_idle got %0d expected 0", sts_state); end
    endtask

    task automatic test_drop_last();
        cfg_length = 32'd2;
        beats.delete();
        step(16'd0, 16'd0, 1'b1, 1'b0, 1'b1);
        step(16'd100, 16'd0, 1'b0, 1'b0, 1'b0);
        step(16'd101, 16'd0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (m_axis_tlast !== 1'b1 || m_axis_tdata !== 32'd100) begin n_fail++; $display("[TB] FAIL droplast_held got l=%b d=%h expected l=1 d=00000064", m_axis_tlast, m_axis_tdata); end
        n_checks++; if (sts_drops !== 32'd4) begin n_fail++; $display("[TB] FAIL droplast_drops got %0d expected 4", sts_drops); end
        step(16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        step(16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (beats.size() != 1 || beats[0] !== {1'b1, 16'd0, 16'd100}) begin n_fail++; $display("[TB] FAIL droplast_beats got n=%0d expected one beat 100000064", beats.size()); end
        n_checks++; if (sts_state !== 2'd0) begin n_fail++; $display("[TB] FAIL droplast_idle got %0d expected 0", sts_state); end
    endtask

    task automatic test_length_zero();
        cfg_length = 32'd0;
        beats.delete();
        step(16'd0, 16'd0, 1'b1, 1'b0, 1'b1);
        step(16'd100, 16'd0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1) begin n_fail++; $display("[TB] FAIL len0_last got v=%b l=%b expected v=1 l=1", m_axis_tvalid, m_axis_tlast); end
        step(16'd101, 16'd0, 1'b0, 1'b0, 1'b1);
        step(16'd102, 16'd0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (beats.size() != 1 || beats[0] !== {1'b1, 16'd0, 16'd100}) begin n_fail++; $display("[TB] FAIL len0_beats got n=%0d expected one beat 100000064", beats.size()); end
        n_checks++; if (sts_state !== 2'd0) begin n_fail++; $display("[TB] FAIL len0_idle got %0d expected 0", sts_state); end
    endtask

    task automatic test_back_to_back();
        cfg_length = 32'd1;
        beats.delete();
        step(16'd0, 16'd0, 1'b1, 1'b0, 1'b1);
        step(16'd100, 16'd0, 1'b0, 1'b0, 1'b1);
        step(16'd0, 16'd0, 1'b1, 1'b0, 1'b1);
        n_checks++; if (sts_state !== 2'd1) begin n_fail++; $display("[TB] FAIL b2b_rearm got %0d expected 1", sts_state); end
        step(16'd50, 16'd0, 1'b0, 1'b0, 1'b1);
        step(16'd120, 16'd0, 1'b0, 1'b0, 1'b1);
        step(16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        step(16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (beats.size() != 2) begin n_fail++; $display("[TB] FAIL b2b_count got %0d expected 2", beats.size()); end
        n_checks++; if (beats.size() == 2 && beats[1] !== {1'b1, 16'd0, 16'd120}) begin n_fail++; $display("[TB] FAIL b2b_beat1 got %h expected 100000078", beats[1]); end
    endtask

    task automatic test_reset_mid();
        cfg_length = 32'd8;
        beats.delete();
        step(16'd0, 16'd0, 1'b1, 1'b0, 1'b1);
        step(16'd100, 16'd0, 1'b0, 1'b0, 1'b1);
        step(16'd101, 16'd0, 1'b0, 1'b0, 1'b1);
        aresetn = 1'b0;
        step(16'd102, 16'd0, 1'b0, 1'b0, 1'b1);
        aresetn = 1'b1;
        n_checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 32'h0) begin n_fail++; $display("[TB] FAIL rstmid_out got v=%b l=%b d=%h expected all 0", m_axis_tvalid, m_axis_tlast, m_axis_tdata); end
        n_checks++; if (sts_state !== 2'd0) begin n_fail++; $display("[TB] FAIL rstmid_state got %0d expected 0", sts_state); end
        n_checks++; if (sts_drops !== 32'd0) begin n_fail++; $display("[TB] FAIL rstmid_drops got %0d expected 0", sts_drops); end
`ifdef AXIS_ZMOD_TRIGGER_TIMESTAMP_EN
        cfg_length = 32'd1;
        step(16'd0, 16'd0, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k < 37; k++) step(16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        step(16'd100, 16'd0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (sts_timestamp !== 64'd37) begin n_fail++; $display("[TB] FAIL ts_value got %0d expected 37", sts_timestamp); end
        step(16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        step(16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (sts_timestamp !== 64'd37) begin n_fail++; $display("[TB] FAIL ts_hold got %0d expected 37", sts_timestamp); end
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got timeout expected end of test");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        aresetn       = 1'b0;
        s_axis_tdata  = 32'h0;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        cfg_level     = 16'd0;
        cfg_chan      = 1'b0;
        cfg_edge      = 1'b0;
        cfg_length    = 32'd1;
        arm           = 1'b0;
        trg_force     = 1'b0;
        test_reset();
        test_rising();
        test_falling_b();
        test_force();
        test_backpressure();
        test_drop_last();
        test_length_zero();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
